// File: rtl/bike_ctrl_pkg.sv
// Shared types and default sizing for the BIKE BGF iteration controller.
package bike_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WEIGHT = 3'd1,
        THRESH = 3'd2,
        FLIP   = 3'd3,
        FIN    = 3'd4
    } bgf_state_t;

    localparam int NBITER_DEF     = 5;
    localparam int COL_BLOCKS_DEF = 24;
    localparam int ADDR_W_DEF     = 5;
    localparam int ITER_W_DEF     = 3;

endpackage

// File: rtl/bike_bgf_iter_ctrl_if.sv
// Handshake bundle between the decoder FSM, the iteration controller and the
// weight/threshold/flip datapaths. The controller takes the slave side.
interface bike_bgf_iter_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int ITER_W = 3
);
    logic              start;
    logic              busy;
    logic              done;
    logic              success;
    logic [ITER_W-1:0] iter;
    logic              wt_start;
    logic              wt_done;
    logic              wt_zero;
    logic              th_start;
    logic              th_done;
    logic              flip_en;
    logic [ADDR_W-1:0] flip_addr;
    logic              flip_ready;
    logic              flip_last;

    modport slave (
        input  start, wt_done, wt_zero, th_done, flip_ready,
        output busy, done, success, iter, wt_start, th_start,
               flip_en, flip_addr, flip_last
    );

    modport master (
        output start, wt_done, wt_zero, th_done, flip_ready,
        input  busy, done, success, iter, wt_start, th_start,
               flip_en, flip_addr, flip_last
    );
endinterface

// File: rtl/bike_ctrl_counter.sv
// Saturating up-counter: sync clear has priority over enable; enable at
// MAX_VALUE holds the count.
module bike_ctrl_counter #(
    parameter int SIZE      = 3,
    parameter int MAX_VALUE = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    output logic [SIZE-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != SIZE'(MAX_VALUE))) begin
            count <= count + SIZE'(1);
        end
    end

endmodule

// File: rtl/bike_bgf_iter_ctrl.sv
// Iteration scheduler for the BIKE BGF decoder: weight -> threshold -> flip
// pass per iteration, ending on zero syndrome or after NBITER passes.
//
//  state  | meaning
//  IDLE   | waiting for start
//  WEIGHT | syndrome weight running; wt_start on first cycle
//  THRESH | threshold running; th_start on first cycle
//  FLIP   | walking column blocks 0..COL_BLOCKS-1 under flip_ready
//  FIN    | one-cycle done pulse
module bike_bgf_iter_ctrl
    import bike_ctrl_pkg::*;
#(
    parameter int NBITER     = NBITER_DEF,
    parameter int COL_BLOCKS = COL_BLOCKS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int ITER_W     = ITER_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    bike_bgf_iter_ctrl_if.slave   bus
);

    bgf_state_t        state;
    bgf_state_t        state_nxt;
    logic              first_q;
    logic              success_q;
    logic              start_acc;
    logic              pass_end;
    logic              succ_set;
    logic              at_last;
    logic              flip_en_w;
    logic [ITER_W-1:0] iter_cnt;
    logic [ADDR_W-1:0] addr_cnt;

    assign flip_en_w = (state == FLIP);
    assign at_last   = (addr_cnt == ADDR_W'(COL_BLOCKS - 1));

    // Done handshakes are qualified with !first_q so a pulse left over from
    // the previous state cannot be mistaken for this state's result.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        pass_end  = 1'b0;
        succ_set  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = WEIGHT;
                    start_acc = 1'b1;
                end
            end
            WEIGHT: begin
                if (!first_q && bus.wt_done) begin
                    if (bus.wt_zero) begin
                        state_nxt = FIN;
                        succ_set  = 1'b1;
                    end else if (iter_cnt >= ITER_W'(NBITER)) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = THRESH;
                    end
                end
            end
            THRESH: begin
                if (!first_q && bus.th_done) begin
                    state_nxt = FLIP;
                end
            end
            FLIP: begin
                if (bus.flip_ready && at_last) begin
                    state_nxt = WEIGHT;
                    pass_end  = 1'b1;
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            first_q   <= 1'b0;
            success_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            first_q <= (state_nxt != state);
            if (start_acc) begin
                success_q <= 1'b0;
            end else if (succ_set) begin
                success_q <= 1'b1;
            end
        end
    end

    bike_ctrl_counter #(
        .SIZE      (ITER_W),
        .MAX_VALUE (NBITER)
    ) u_iter_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start_acc),
        .en    (pass_end),
        .count (iter_cnt)
    );

    // Cleared at pass end so every FLIP entry starts at block 0.
    bike_ctrl_counter #(
        .SIZE      (ADDR_W),
        .MAX_VALUE (COL_BLOCKS - 1)
    ) u_addr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (pass_end | start_acc),
        .en    (flip_en_w & bus.flip_ready),
        .count (addr_cnt)
    );

    assign bus.busy      = (state == WEIGHT) || (state == THRESH) || (state == FLIP);
    assign bus.done      = (state == FIN);
    assign bus.success   = success_q;
    assign bus.iter      = iter_cnt;
    assign bus.wt_start  = (state == WEIGHT) && first_q;
    assign bus.th_start  = (state == THRESH) && first_q;
    assign bus.flip_en   = flip_en_w;
    assign bus.flip_addr = addr_cnt;
    assign bus.flip_last = flip_en_w & at_last;

endmodule

// File: tb/tb_bike_bgf_iter_ctrl.sv
// Bench for bike_bgf_iter_ctrl: reactive datapath model drives random
// latencies/stalls and predicts the controller's cycle-level behaviour.
module tb_bike_bgf_iter_ctrl;

    localparam int NBITER     = 5;
    localparam int COL_BLOCKS = 24;
    localparam int ADDR_W     = 5;
    localparam int ITER_W     = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    bike_bgf_iter_ctrl_if #(.ADDR_W(ADDR_W), .ITER_W(ITER_W)) bus ();

    bike_bgf_iter_ctrl #(
        .NBITER     (NBITER),
        .COL_BLOCKS (COL_BLOCKS),
        .ADDR_W     (ADDR_W),
        .ITER_W     (ITER_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full decode. zero_at = weight index that reports zero (-1: never).
    // stall_mode: 0 always ready, 1 random stalls, 2 three stalls at block 7.
    // inject: spurious start/wt_done/th_done outside their own states.
    task automatic run_decode(input int zero_at, input int stall_mode, input bit inject,
                              input string tag);
        logic [5:0] obs, exp;
        int  w, t, ea, stalls, cyc;
        bit  fin, ready, pass_done;
        fin = 1'b0;
        bus.start = 1'b1;
        tick;
        for (int k = 0; k <= NBITER && !fin; k++) begin
            obs = {bus.busy, bus.done, bus.wt_start, bus.th_start, bus.flip_en, bus.flip_last};
            exp = 6'b101000;
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL %s wt_entry k=%0d: ctl got %b want %b", tag, k, obs, exp);
            end
            n_vec++;
            if (bus.iter !== ITER_W'(k)) begin
                n_err++;
                $display("FAIL %s iter_entry k=%0d: got %0d want %0d", tag, k, bus.iter, k);
            end
            if (k == 0) begin
                n_vec++;
                if (bus.success !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s success_clr: got %b want 0", tag, bus.success);
                end
            end
            bus.start   = inject ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.wt_done = inject;
            bus.wt_zero = inject;
            bus.th_done = inject;
            w = $urandom_range(1, 4);
            for (int c = 1; c <= w; c++) begin
                tick;
                obs = {bus.busy, bus.done, bus.wt_start, bus.th_start, bus.flip_en, bus.flip_last};
                exp = 6'b100000;
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL %s wt_wait k=%0d c=%0d: ctl got %b want %b", tag, k, c, obs, exp);
                end
                bus.start   = inject ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.th_done = 1'b0;
                bus.wt_done = (c == w);
                bus.wt_zero = (c == w) && (k == zero_at);
            end
            tick;
            bus.wt_done = 1'b0;
            bus.wt_zero = 1'b0;
            if (k == zero_at || k == NBITER) begin
                bus.start = 1'b0;
                obs = {bus.busy, bus.done, bus.wt_start, bus.th_start, bus.flip_en, bus.flip_last};
                exp = 6'b010000;
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL %s fin_ctl: got %b want %b", tag, obs, exp);
                end
                n_vec++;
                if (bus.iter !== ITER_W'(k)) begin
                    n_err++;
                    $display("FAIL %s fin_iter: got %0d want %0d", tag, bus.iter, k);
                end
                n_vec++;
                if (bus.success !== (k == zero_at)) begin
                    n_err++;
                    $display("FAIL %s fin_success: got %b want %b", tag, bus.success, (k == zero_at));
                end
                tick;
                obs = {bus.busy, bus.done, bus.wt_start, bus.th_start, bus.flip_en, bus.flip_last};
                n_vec++;
                if (obs !== 6'b000000) begin
                    n_err++;
                    $display("FAIL %s idle_after_fin: ctl got %b want 000000", tag, obs);
                end
                fin = 1'b1;
            end else begin
                obs = {bus.busy, bus.done, bus.wt_start, bus.th_start, bus.flip_en, bus.flip_last};
                exp = 6'b100100;
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL %s th_entry k=%0d: ctl got %b want %b", tag, k, obs, exp);
                end
                bus.wt_done = inject;
                bus.wt_zero = inject ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.th_done = inject;
                t = $urandom_range(1, 4);
                for (int c = 1; c <= t; c++) begin
                    tick;
                    obs = {bus.busy, bus.done, bus.wt_start, bus.th_start, bus.flip_en, bus.flip_last};
                    exp = 6'b100000;
                    n_vec++;
                    if (obs !== exp) begin
                        n_err++;
                        $display("FAIL %s th_wait k=%0d c=%0d: ctl got %b want %b", tag, k, c, obs, exp);
                    end
                    bus.start   = inject ? 1'($urandom_range(0, 1)) : 1'b0;
                    bus.wt_done = inject ? 1'($urandom_range(0, 1)) : 1'b0;
                    bus.th_done = (c == t);
                end
                tick;
                bus.th_done = 1'b0;
                ea = 0;
                stalls = 0;
                pass_done = 1'b0;
                for (cyc = 0; cyc < 200 && !pass_done; cyc++) begin
                    obs = {bus.busy, bus.done, bus.wt_start, bus.th_start, bus.flip_en, bus.flip_last};
                    exp = {5'b10001, (ea == COL_BLOCKS - 1)};
                    n_vec++;
                    if (obs !== exp) begin
                        n_err++;
                        $display("FAIL %s flip_ctl k=%0d addr=%0d: ctl got %b want %b", tag, k, ea, obs, exp);
                    end
                    n_vec++;
                    if (bus.flip_addr !== ADDR_W'(ea)) begin
                        n_err++;
                        $display("FAIL %s flip_addr k=%0d: got %0d want %0d", tag, k, bus.flip_addr, ea);
                    end
                    case (stall_mode)
                        1:       ready = ($urandom_range(0, 3) != 0);
                        2:       ready = !(ea == 7 && stalls < 3);
                        default: ready = 1'b1;
                    endcase
                    bus.flip_ready = ready;
                    bus.start      = inject ? 1'($urandom_range(0, 1)) : 1'b0;
                    bus.wt_done    = inject ? 1'($urandom_range(0, 1)) : 1'b0;
                    bus.wt_zero    = inject ? 1'($urandom_range(0, 1)) : 1'b0;
                    bus.th_done    = inject ? 1'($urandom_range(0, 1)) : 1'b0;
                    tick;
                    if (!ready) stalls++;
                    else if (ea == COL_BLOCKS - 1) pass_done = 1'b1;
                    else ea++;
                end
                bus.flip_ready = 1'b0;
                bus.start      = 1'b0;
                bus.wt_done    = 1'b0;
                bus.wt_zero    = 1'b0;
                bus.th_done    = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        logic [ITER_W+ADDR_W+7-1:0] obs;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.wt_done    = 1'b0;
        bus.wt_zero    = 1'b0;
        bus.th_done    = 1'b0;
        bus.flip_ready = 1'b0;
        repeat (3) tick;
        obs = {bus.busy, bus.done, bus.success, bus.iter, bus.wt_start, bus.th_start,
               bus.flip_en, bus.flip_addr, bus.flip_last};
        n_vec++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want all zero", obs);
        end
        reset = 1'b0;
        tick;
        obs = {bus.busy, bus.done, bus.success, bus.iter, bus.wt_start, bus.th_start,
               bus.flip_en, bus.flip_addr, bus.flip_last};
        n_vec++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b want all zero", obs);
        end
    endtask

    task automatic test_zero_first;
        run_decode(0, 0, 1'b0, "zero_first");
    endtask

    task automatic test_reset_mid_flip;
        logic [ITER_W+ADDR_W+7-1:0] obs;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        bus.wt_done = 1'b1;
        tick;
        bus.wt_done = 1'b0;
        tick;
        bus.th_done = 1'b1;
        tick;
        bus.th_done    = 1'b0;
        bus.flip_ready = 1'b1;
        repeat (9) tick;
        n_vec++;
        if (bus.flip_addr !== ADDR_W'(9) || bus.flip_en !== 1'b1) begin
            n_err++;
            $display("FAIL mid_flip_addr: got addr %0d en %b want addr 9 en 1", bus.flip_addr, bus.flip_en);
        end
        #2;
        reset = 1'b1;
        #1;
        obs = {bus.busy, bus.done, bus.success, bus.iter, bus.wt_start, bus.th_start,
               bus.flip_en, bus.flip_addr, bus.flip_last};
        n_vec++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL async_reset_outputs: got %b want all zero", obs);
        end
        bus.flip_ready = 1'b0;
        tick;
        reset = 1'b0;
        repeat (2) begin
            tick;
            obs = {bus.busy, bus.done, bus.success, bus.iter, bus.wt_start, bus.th_start,
                   bus.flip_en, bus.flip_addr, bus.flip_last};
            n_vec++;
            if (obs !== '0) begin
                n_err++;
                $display("FAIL post_reset_idle: got %b want all zero", obs);
            end
        end
        run_decode(1, 0, 1'b0, "after_reset");
    endtask

    task automatic test_max_iter;
        run_decode(-1, 0, 1'b0, "max_iter");
    endtask

    task automatic test_stall;
        run_decode(1, 2, 1'b0, "stall_at_7");
    endtask

    task automatic test_inject;
        run_decode(2, 1, 1'b1, "inject");
    endtask

    task automatic test_late_success;
        run_decode(3, 0, 1'b0, "late_success");
        repeat (5) begin
            tick;
            n_vec++;
            if (bus.success !== 1'b1 || bus.iter !== ITER_W'(3)) begin
                n_err++;
                $display("FAIL success_hold: got success %b iter %0d want 1 3", bus.success, bus.iter);
            end
        end
        run_decode(-1, 1, 1'b0, "after_success");
    endtask

    task automatic test_random;
        int z;
        for (int i = 0; i < 6; i++) begin
            z = $urandom_range(0, 6);
            run_decode((z == 6) ? -1 : z, 1, 1'($urandom_range(0, 1)), "random");
            repeat ($urandom_range(0, 3)) tick;
        end
    endtask

    initial begin
        test_reset();
        test_zero_first();
        test_reset_mid_flip();
        test_max_iter();
        test_stall();
        test_inject();
        test_late_success();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
